lpc_ring_writer: RTL

Parametrised successor to the single-slot LPC frame-to-memory serialiser. Captures completed LPC frames into a small pending FIFO and writes each one as a fixed 8-byte record into a 2**RING_AW-slot ring buffer RAM. Applies ring backpressure against a consumer read pointer and counts dropped frames. Sits between the LPC decoder (frame_valid, same clock domain) and the dual-port capture RAM read by the UART/readout logic.

---
 rtl/lpc_ring_pkg.sv | 50 +++++
 rtl/lpc_frame_fifo.sv | 42 ++++
 rtl/lpc_ring_writer.sv | 113 +++++++++++
 3 files changed

// File: rtl/lpc_ring_pkg.sv
// lpc_ring_pkg: record layout, FSM encoding and pending-frame entry shared by lpc_ring_writer
// Build option LPC_RING_TIMESTAMP_EN adds a 16-bit timestamp to each entry and record (bytes 6-7).
package lpc_ring_pkg;

   localparam int REC_BYTES_LOG2 = 3;

   localparam logic [2:0] OFF_TYPE  = 3'd0;
   localparam logic [2:0] OFF_ADDR3 = 3'd1;
   localparam logic [2:0] OFF_ADDR2 = 3'd2;
   localparam logic [2:0] OFF_ADDR1 = 3'd3;
   localparam logic [2:0] OFF_ADDR0 = 3'd4;
   localparam logic [2:0] OFF_DATA  = 3'd5;
   localparam logic [2:0] OFF_TS_HI = 3'd6;
   localparam logic [2:0] OFF_TS_LO = 3'd7;

`ifdef LPC_RING_TIMESTAMP_EN
   localparam logic [2:0] OFF_LAST = OFF_TS_LO;
`else
   localparam logic [2:0] OFF_LAST = OFF_DATA;
`endif

   typedef enum logic [1:0] {IDLE, WRITE, COMMIT} state_t;

   typedef struct packed {
      logic [3:0]  cyctype_dir;
      logic [31:0] addr;
      logic [7:0]  data;
`ifdef LPC_RING_TIMESTAMP_EN
      logic [15:0] ts;
`endif
   } frame_t;

   localparam int FRAME_W = $bits(frame_t);

   // Byte of the ring record at a given offset within the slot
   function automatic logic [7:0] rec_byte(input frame_t f, input logic [2:0] off);
      return off == OFF_TYPE  ? {4'h0, f.cyctype_dir} :
             off == OFF_ADDR3 ? f.addr[31:24] :
             off == OFF_ADDR2 ? f.addr[23:16] :
             off == OFF_ADDR1 ? f.addr[15:8]  :
             off == OFF_ADDR0 ? f.addr[7:0]   :
`ifdef LPC_RING_TIMESTAMP_EN
             off == OFF_DATA  ? f.data        :
             off == OFF_TS_HI ? f.ts[15:8]    : f.ts[7:0];
`else
             (off == OFF_TS_HI || off == OFF_TS_LO) ? 8'h00 : f.data;
`endif
   endfunction

endpackage

// File: rtl/lpc_frame_fifo.sv
// lpc_frame_fifo: small synchronous FIFO for pending LPC frames; writes while full are ignored.
module lpc_frame_fifo #(
   parameter int WIDTH   = 44,
   parameter int PEND_AW = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_din,
   output logic [WIDTH-1:0] o_dout,
   output logic             o_full,
   output logic             o_empty
);

   logic [WIDTH-1:0] r_mem [2**PEND_AW];
   logic [PEND_AW:0] r_wp;
   logic [PEND_AW:0] r_rp;
   logic             w_wr;
   logic             w_rd;

   assign w_wr    = i_push && !o_full;
   assign w_rd    = i_pop && !o_empty;
   assign o_empty = r_wp == r_rp;
   assign o_full  = (r_wp[PEND_AW] != r_rp[PEND_AW]) && (r_wp[PEND_AW-1:0] == r_rp[PEND_AW-1:0]);
   assign o_dout  = r_mem[r_rp[PEND_AW-1:0]];

   // Entry storage, written only when there is room
   always_ff @(posedge clock)
      if (w_wr) r_mem[r_wp[PEND_AW-1:0]] <= i_din;

   // Wrap-bit pointers distinguish full from empty
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         r_wp <= '0;
         r_rp <= '0;
      end else begin
         if (w_wr) r_wp <= r_wp + (PEND_AW+1)'(1);
         if (w_rd) r_rp <= r_rp + (PEND_AW+1)'(1);
      end

endmodule

// File: rtl/lpc_ring_writer.sv
// lpc_ring_writer: queues LPC frames and serialises each into an 8-byte slot of a capture ring RAM.
// Build option LPC_RING_TIMESTAMP_EN: stamp each frame with a free-running 16-bit cycle counter.
module lpc_ring_writer
   import lpc_ring_pkg::*;
#(
   parameter int RING_AW = 5,
   parameter int PEND_AW = 2,
   parameter int DROP_W  = 8
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        frame_valid,
   input  logic [3:0]                  lpc_cyctype_dir,
   input  logic [31:0]                 lpc_addr,
   input  logic [7:0]                  lpc_data,
   input  logic [RING_AW-1:0]          rd_ptr,
   input  logic                        drop_clear,
   output logic [RING_AW+REC_BYTES_LOG2-1:0] ram_addr,
   output logic [7:0]                  ram_data,
   output logic                        ram_we,
   output logic [RING_AW-1:0]          wr_ptr,
   output logic                        frame_done,
   output logic                        ring_full,
   output logic [DROP_W-1:0]           drop_count
);

   state_t                    r_state;
   frame_t                    r_frame;
   frame_t                    w_push;
   frame_t                    w_head;
   logic                      w_full;
   logic                      w_empty;
   logic                      w_pop;
   logic                      w_drop;
   logic [REC_BYTES_LOG2-1:0] w_next_off;

`ifdef LPC_RING_TIMESTAMP_EN
   logic [15:0] r_ts;

   // Free-running timestamp sampled into each frame as it is queued
   always_ff @(posedge clock or negedge reset)
      if (!reset) r_ts <= '0;
      else        r_ts <= r_ts + 16'd1;

   assign w_push = {lpc_cyctype_dir, lpc_addr, lpc_data, r_ts};
`else
   assign w_push = {lpc_cyctype_dir, lpc_addr, lpc_data};
`endif

   assign ring_full  = (wr_ptr + RING_AW'(1)) == rd_ptr;
   assign w_pop      = (r_state == IDLE) && !w_empty && !ring_full;
   assign w_drop     = frame_valid && w_full;
   assign w_next_off = ram_addr[REC_BYTES_LOG2-1:0] + 3'd1;

   lpc_frame_fifo #(
      .WIDTH   (FRAME_W),
      .PEND_AW (PEND_AW)
   ) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .i_push  (frame_valid),
      .i_pop   (w_pop),
      .i_din   (w_push),
      .o_dout  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // Record serialiser: pop one frame, emit its bytes one per cycle, then commit the slot
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         r_state    <= IDLE;
         r_frame    <= '0;
         ram_we     <= 1'b0;
         ram_addr   <= '0;
         ram_data   <= '0;
         wr_ptr     <= '0;
         frame_done <= 1'b0;
      end else begin
         case (r_state)
            IDLE:
               if (w_pop) begin
                  r_frame  <= w_head;
                  ram_we   <= 1'b1;
                  ram_addr <= {wr_ptr, OFF_TYPE};
                  ram_data <= rec_byte(w_head, OFF_TYPE);
                  r_state  <= WRITE;
               end
            WRITE:
               if (ram_addr[REC_BYTES_LOG2-1:0] == OFF_LAST) begin
                  ram_we     <= 1'b0;
                  wr_ptr     <= wr_ptr + RING_AW'(1);
                  frame_done <= 1'b1;
                  r_state    <= COMMIT;
               end else begin
                  ram_addr <= {wr_ptr, w_next_off};
                  ram_data <= rec_byte(r_frame, w_next_off);
               end
            COMMIT: begin
               frame_done <= 1'b0;
               r_state    <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end

   // Saturating count of frames lost because the pending FIFO was full
   always_ff @(posedge clock or negedge reset)
      if (!reset)                           drop_count <= '0;
      else if (drop_clear)                  drop_count <= DROP_W'(w_drop);
      else if (w_drop && !(&drop_count))    drop_count <= drop_count + DROP_W'(1);

endmodule
